// File: rtl/router_pkg.sv
// Shared types for the router receive side: FSM state encoding and header layout.
package router_pkg;

  localparam int ROUTER_ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_WAIT,
    PAYLOAD,
    PARITY,
    DONE
  } rx_state_e;

  typedef struct packed {
    logic [5:0]               len;
    logic [ROUTER_ADDR_W-1:0] addr;
  } router_hdr_t;

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry byte skid buffer carrying a last-of-packet flag; entry 0 is the head.
module router_skid_buf (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       head_last,
  output logic [1:0] count,
  output logic       empty
);

  logic [7:0] data0_q;
  logic [7:0] data1_q;
  logic       last0_q;
  logic       last1_q;
  logic [1:0] cnt_q;

  // Storage and occupancy; a simultaneous push and pop keeps the count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data0_q <= 8'd0;
      data1_q <= 8'd0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            data0_q <= push_data;
            last0_q <= push_last;
          end else begin
            data1_q <= push_data;
            last1_q <= push_last;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          data0_q <= data1_q;
          last0_q <= last1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            data0_q <= push_data;
            last0_q <= push_last;
          end else begin
            data0_q <= data1_q;
            last0_q <= last1_q;
            data1_q <= push_data;
            last1_q <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = data0_q;
  assign head_last = last0_q;
  assign count     = cnt_q;
  assign empty     = (cnt_q == 2'd0);

endmodule

// File: rtl/router_rx_port.sv
// Router output-port consumer: drains the port FIFO, reframes packets as a
// valid/ready byte stream (header + payload), checks the trailing parity byte.
// Optional feature macro: ROUTER_RX_STATS_EN adds pkt_cnt / err_cnt outputs.
module router_rx_port
  import router_pkg::*;
#(
  parameter int PORT_ID   = 0,
  parameter int STALL_MAX = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  fifo_data,
  output logic        read_enb,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        addr_err,
  output logic        stall_warn
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_CAP = STALL_W'(STALL_MAX);

  rx_state_e          state_q;
  rx_state_e          state_d;
  logic               rd_q;
  logic [7:0]         acc_q;
  logic [5:0]         rem_q;
  logic               perr_q;
  logic [STALL_W-1:0] stall_cnt_q;

  router_hdr_t        hdr_in;
  logic               push;
  logic               push_last;
  logic               pop;
  logic [1:0]         skid_cnt;
  logic               skid_empty;

  assign hdr_in = router_hdr_t'(fifo_data);

  router_skid_buf u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (fifo_data),
    .push_last (push_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .count     (skid_cnt),
    .empty     (skid_empty)
  );

  assign m_valid = !skid_empty;
  assign pop     = m_valid && m_ready;

  // Next-state and per-state strobes. A header read is only started when the
  // skid has a free slot, and payload reads are credited against skid occupancy
  // plus the read in flight, so the skid can never overflow.
  always_comb begin
    state_d    = state_q;
    read_enb   = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    pkt_done   = 1'b0;
    parity_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld_out && (skid_cnt != 2'd2)) state_d = HDR_RD;
      end
      HDR_RD: begin
        read_enb = 1'b1;
        state_d  = HDR_WAIT;
      end
      HDR_WAIT: begin
        push      = 1'b1;
        push_last = (hdr_in.len == 6'd0);
        state_d   = (hdr_in.len == 6'd0) ? PARITY : PAYLOAD;
      end
      PAYLOAD: begin
        // rem counts bytes not yet returned; subtract the one in flight.
        read_enb = vld_out && (rem_q > {5'd0, rd_q}) &&
                   (({1'b0, skid_cnt} + {2'b00, rd_q}) < 3'd2);
        if (rd_q) begin
          push      = 1'b1;
          push_last = (rem_q == 6'd1);
          if (rem_q == 6'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        read_enb = vld_out && !rd_q;
        if (rd_q) state_d = DONE;
      end
      DONE: begin
        pkt_done   = 1'b1;
        parity_err = perr_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, read-return tracking, parity accumulation and header checks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      acc_q    <= 8'd0;
      rem_q    <= 6'd0;
      perr_q   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= read_enb;
      addr_err <= 1'b0;
      case (state_q)
        HDR_WAIT: begin
          acc_q    <= fifo_data;
          rem_q    <= hdr_in.len;
          addr_err <= (hdr_in.addr != ROUTER_ADDR_W'(PORT_ID));
        end
        PAYLOAD: begin
          if (rd_q) begin
            acc_q <= acc_q ^ fifo_data;
            rem_q <= rem_q - 6'd1;
          end
        end
        PARITY: begin
          if (rd_q) perr_q <= (fifo_data != acc_q);
        end
        default: ;
      endcase
    end
  end

  // Back-pressure watchdog: saturating count of cycles a byte waits unaccepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (m_valid && m_ready) begin
      stall_cnt_q <= '0;
    end else if (m_valid && (stall_cnt_q != STALL_CAP)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_warn = (stall_cnt_q >= STALL_CAP);

`ifdef ROUTER_RX_STATS_EN
  // Wrapping packet and error counters; one error per cycle at most.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
      if (parity_err || addr_err) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
